// File: rtl/game_pkg.sv
// Shared game constants, state encodings and the bullet/enemy overlap test.
// SHOT_COOLDOWN_EN adds the shot-lockout constants.
package game_pkg;

  localparam int unsigned X_W    = 10;
  localparam int unsigned Y_W    = 9;
  localparam int unsigned CALC_W = 11;

  // Screen geometry; player sprite spans X-10..X+20 inside the border
  localparam int unsigned SCREEN_W       = 640;
  localparam int unsigned BORDER_W       = 11;
  localparam int unsigned PLAYER_LEFT_W  = 10;
  localparam int unsigned PLAYER_RIGHT_W = 20;

  localparam int unsigned X_MIN       = BORDER_W + PLAYER_LEFT_W;
  localparam int unsigned X_MAX       = SCREEN_W - BORDER_W - PLAYER_RIGHT_W;
  localparam int unsigned X_START     = 315;
  localparam int unsigned PLAYER_Y    = 440;
  localparam int unsigned PLAYER_STEP = 2;

  localparam int unsigned BULLET_STEP  = 4;
  localparam int unsigned BULLET_Y_MIN = BORDER_W;
  localparam int unsigned LAUNCH_DY    = 20;

  localparam int unsigned HIT_W    = 20;
  localparam int unsigned BULLET_H = 10;
  localparam int unsigned ENEMY_H  = 20;

`ifdef SHOT_COOLDOWN_EN
  localparam int unsigned COOLDOWN_TICKS = 15;
  localparam int unsigned CD_W           = $clog2(COOLDOWN_TICKS + 1);
`endif

  typedef enum logic [1:0] {GS_WAIT_START, GS_PLAY, GS_WON} game_st_e;
  typedef enum logic [1:0] {MV_HALT, MV_LEFT, MV_RIGHT} motion_e;
  typedef enum logic {BS_PARKED, BS_FLYING} bullet_st_e;

  // Bullet box vs enemy box, widened so sums cannot wrap
  function automatic logic hit_test(input logic [X_W-1:0] bx, input logic [Y_W-1:0] by,
                                    input logic [X_W-1:0] ex, input logic [Y_W-1:0] ey);
    logic [CALC_W-1:0] bx_w, by_w, ex_w, ey_w;
    bx_w = CALC_W'(bx);
    by_w = CALC_W'(by);
    ex_w = CALC_W'(ex);
    ey_w = CALC_W'(ey);
    return (bx_w + CALC_W'(HIT_W) > ex_w) && (bx_w < ex_w + CALC_W'(HIT_W)) &&
           (by_w + CALC_W'(BULLET_H) > ey_w) && (by_w < ey_w + CALC_W'(ENEMY_H));
  endfunction

endpackage

// File: rtl/update_tick_gen.sv
// Free-running divider producing a single-cycle update tick every TICK_DIV clocks.
module update_tick_gen #(
  parameter int unsigned TICK_DIV = 833333
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick_c
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] r_cnt;

  assign o_tick_c = (r_cnt == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (o_tick_c) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/player_motion_ctrl.sv
// Player/bullet game logic: keypad levels -> player and bullet positions, sticky win on hit.
// Build macro SHOT_COOLDOWN_EN enables a shot lockout after the bullet parks.
module player_motion_ctrl
  import game_pkg::*;
#(
  parameter int unsigned TICK_DIV = 833333
) (
  input  logic           master_clk,
  input  logic           resetn,
  input  logic           start,
  input  logic           left,
  input  logic           right,
  input  logic           stop,
  input  logic           shoot,
  input  logic           lose,
  input  logic [X_W-1:0] enemyXPosition,
  input  logic [Y_W-1:0] enemyYPosition,
  output logic [X_W-1:0] playerXPosition,
  output logic [Y_W-1:0] playerYPosition,
  output logic [X_W-1:0] bulletXPosition,
  output logic [Y_W-1:0] bulletYPosition,
  output logic           win
);

  logic              w_tick;
  game_st_e          r_game_st, w_game_nxt;
  bullet_st_e        r_bullet_st, w_bullet_nxt;
  motion_e           r_motion, w_motion_nxt;
  logic [X_W-1:0]    r_player_x, r_bullet_x, w_player_x_nxt;
  logic [Y_W-1:0]    r_bullet_y;
  logic              r_win, r_start_d, r_shoot_d, r_shot_pend;
  logic              w_start_rise, w_shoot_rise, w_step, w_shot_ok;
  logic              w_launch, w_hit, w_retire;
  logic [CALC_W-1:0] w_x_ext, w_x_sum;

  update_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .i_clk    (master_clk),
    .i_rst_n  (resetn),
    .o_tick_c (w_tick)
  );

  assign w_start_rise = start & ~r_start_d;
  assign w_shoot_rise = shoot & ~r_shoot_d;
  assign w_step       = w_tick & (r_game_st == GS_PLAY) & ~lose;

`ifdef SHOT_COOLDOWN_EN
  logic [CD_W-1:0] r_cooldown;

  assign w_shot_ok = (r_shot_pend | w_shoot_rise) & (r_cooldown == '0);

  // Lockout reloads whenever a flying bullet parks; cleared on game restart
  always_ff @(posedge master_clk or negedge resetn) begin
    if (!resetn) begin
      r_cooldown <= '0;
    end else if (w_start_rise) begin
      r_cooldown <= '0;
    end else if (w_hit || w_retire) begin
      r_cooldown <= CD_W'(COOLDOWN_TICKS);
    end else if (w_step && (r_cooldown != '0)) begin
      r_cooldown <= r_cooldown - CD_W'(1);
    end
  end
`else
  assign w_shot_ok = r_shot_pend | w_shoot_rise;
`endif

  assign w_launch = w_step & w_shot_ok & (r_bullet_st == BS_PARKED);
  assign w_hit    = w_step & (r_bullet_st == BS_FLYING) &
                    hit_test(r_bullet_x, r_bullet_y, enemyXPosition, enemyYPosition);
  assign w_retire = w_step & (r_bullet_st == BS_FLYING) & ~w_hit &
                    (r_bullet_y < Y_W'(BULLET_Y_MIN + BULLET_STEP));

  // Next state for game, motion latch and bullet
  always_comb begin
    w_game_nxt   = r_game_st;
    w_bullet_nxt = r_bullet_st;
    w_motion_nxt = r_motion;
    if (stop) begin
      w_motion_nxt = MV_HALT;
    end else if (left) begin
      w_motion_nxt = MV_LEFT;
    end else if (right) begin
      w_motion_nxt = MV_RIGHT;
    end
    if (w_start_rise) begin
      w_game_nxt   = GS_PLAY;
      w_bullet_nxt = BS_PARKED;
    end else begin
      if (w_hit) begin
        w_game_nxt = GS_WON;
      end
      if (w_hit || w_retire) begin
        w_bullet_nxt = BS_PARKED;
      end else if (w_launch) begin
        w_bullet_nxt = BS_FLYING;
      end
    end
  end

  // Clamped player step, computed wide so the clamp sees no wrap
  always_comb begin
    w_x_ext        = CALC_W'(r_player_x);
    w_x_sum        = w_x_ext + CALC_W'(PLAYER_STEP);
    w_player_x_nxt = r_player_x;
    case (r_motion)
      MV_LEFT:  w_player_x_nxt = (w_x_ext < CALC_W'(X_MIN + PLAYER_STEP)) ?
                                 X_W'(X_MIN) : X_W'(w_x_ext - CALC_W'(PLAYER_STEP));
      MV_RIGHT: w_player_x_nxt = (w_x_sum > CALC_W'(X_MAX)) ? X_W'(X_MAX) : X_W'(w_x_sum);
      default:  w_player_x_nxt = r_player_x;
    endcase
  end

  always_ff @(posedge master_clk or negedge resetn) begin
    if (!resetn) begin
      r_game_st   <= GS_WAIT_START;
      r_bullet_st <= BS_PARKED;
      r_motion    <= MV_HALT;
    end else begin
      r_game_st   <= w_game_nxt;
      r_bullet_st <= w_bullet_nxt;
      r_motion    <= w_motion_nxt;
    end
  end

  always_ff @(posedge master_clk or negedge resetn) begin
    if (!resetn) begin
      r_player_x  <= X_W'(X_START);
      r_bullet_x  <= '0;
      r_bullet_y  <= '0;
      r_win       <= 1'b0;
      r_shot_pend <= 1'b0;
      r_start_d   <= 1'b0;
      r_shoot_d   <= 1'b0;
    end else begin
      r_start_d <= start;
      r_shoot_d <= shoot;
      if (w_start_rise) begin
        r_player_x  <= X_W'(X_START);
        r_bullet_x  <= '0;
        r_bullet_y  <= '0;
        r_win       <= 1'b0;
        r_shot_pend <= 1'b0;
      end else begin
        // A pending shot lives only until the next tick, used or not
        if (w_tick) begin
          r_shot_pend <= 1'b0;
        end else if (w_shoot_rise) begin
          r_shot_pend <= 1'b1;
        end
        if (w_step) begin
          r_player_x <= w_player_x_nxt;
        end
        if (w_hit || w_retire) begin
          r_bullet_x <= '0;
          r_bullet_y <= '0;
        end else if (w_launch) begin
          r_bullet_x <= r_player_x;
          r_bullet_y <= Y_W'(PLAYER_Y - LAUNCH_DY);
        end else if (w_step && (r_bullet_st == BS_FLYING)) begin
          r_bullet_y <= r_bullet_y - Y_W'(BULLET_STEP);
        end
        if (w_hit) begin
          r_win <= 1'b1;
        end
      end
    end
  end

  assign playerXPosition = r_player_x;
  assign playerYPosition = Y_W'(PLAYER_Y);
  assign bulletXPosition = r_bullet_x;
  assign bulletYPosition = r_bullet_y;
  assign win             = r_win;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Bench for player_motion_ctrl: directed vector table, reset sequence, random run vs model.
module tb_player_motion_ctrl;

  localparam int unsigned TD = 4;
`ifdef SHOT_COOLDOWN_EN
  localparam int COOL = 15;
`else
  localparam int COOL = 0;
`endif

  logic       master_clk = 1'b0;
  logic       resetn = 1'b1;
  logic       start = 1'b0, left = 1'b0, right = 1'b0, stop = 1'b0, shoot = 1'b0, lose = 1'b0;
  logic [9:0] enemyXPosition = 10'd900;
  logic [8:0] enemyYPosition = 9'd100;
  logic [9:0] playerXPosition, bulletXPosition;
  logic [8:0] playerYPosition, bulletYPosition;
  logic       win;

  int n_vec = 0;
  int n_err = 0;
  int n_prints = 0;
  bit chk_en = 1'b0;

  int m_cnt, m_x, m_bx, m_by, m_win, m_game, m_mot, m_fly, m_pend, m_cd, m_sd, m_shd;

  typedef struct {
    logic st, l, r, sp, sh, lo;
    int ex, ey, ticks, x, bx, by, w;
  } row_t;
  row_t tbl[$];

  player_motion_ctrl #(.TICK_DIV(TD)) dut (
    .master_clk      (master_clk),
    .resetn          (resetn),
    .start           (start),
    .left            (left),
    .right           (right),
    .stop            (stop),
    .shoot           (shoot),
    .lose            (lose),
    .enemyXPosition  (enemyXPosition),
    .enemyYPosition  (enemyYPosition),
    .playerXPosition (playerXPosition),
    .playerYPosition (playerYPosition),
    .bulletXPosition (bulletXPosition),
    .bulletYPosition (bulletYPosition),
    .win             (win)
  );

  always #5 master_clk = ~master_clk;

  task automatic m_reset();
    m_cnt = 0; m_x = 315; m_bx = 0; m_by = 0; m_win = 0; m_game = 0;
    m_mot = 0; m_fly = 0; m_pend = 0; m_cd = 0; m_sd = 0; m_shd = 0;
  endtask

  // Reference: game 0=waiting 1=playing 2=won; motion 0=halt 1=left 2=right
  task automatic m_step();
    bit srise, shrise, tick, req;
    int cd_now;
    srise  = start && !m_sd;
    shrise = shoot && !m_shd;
    tick   = (m_cnt == TD - 1);
    m_cnt  = tick ? 0 : m_cnt + 1;
    if (srise) begin
      m_game = 1; m_x = 315; m_bx = 0; m_by = 0; m_fly = 0; m_win = 0; m_pend = 0; m_cd = 0;
    end else if (tick) begin
      req = m_pend || shrise;
      m_pend = 0;
      if (m_game == 1 && !lose) begin
        cd_now = m_cd;
        if (m_cd > 0) m_cd = m_cd - 1;
        if (m_fly) begin
          if (m_bx + 20 > enemyXPosition && m_bx < enemyXPosition + 20 &&
              m_by + 10 > enemyYPosition && m_by < enemyYPosition + 20) begin
            m_win = 1; m_fly = 0; m_bx = 0; m_by = 0; m_game = 2; m_cd = COOL;
          end else if (m_by < 15) begin
            m_fly = 0; m_bx = 0; m_by = 0; m_cd = COOL;
          end else begin
            m_by = m_by - 4;
          end
        end else if (req && cd_now == 0) begin
          m_fly = 1; m_bx = m_x; m_by = 420;
        end
        if (m_mot == 1) m_x = (m_x - 2 < 21) ? 21 : m_x - 2;
        else if (m_mot == 2) m_x = (m_x + 2 > 609) ? 609 : m_x + 2;
      end
    end else if (shrise) begin
      m_pend = 1;
    end
    if (stop) m_mot = 0;
    else if (left) m_mot = 1;
    else if (right) m_mot = 2;
    m_sd  = start;
    m_shd = shoot;
  endtask

  always @(posedge master_clk or negedge resetn) begin
    if (!resetn) m_reset();
    else m_step();
  end

  always @(negedge master_clk) begin
    if (chk_en) begin
      n_vec++;
      if (playerXPosition !== 10'(m_x) || playerYPosition !== 9'd440 ||
          bulletXPosition !== 10'(m_bx) || bulletYPosition !== 9'(m_by) || win !== 1'(m_win)) begin
        n_err++;
        if (n_prints < 20) begin
          n_prints++;
          $display("FAIL model t=%0t got x=%0d y=%0d bx=%0d by=%0d win=%0d want x=%0d y=440 bx=%0d by=%0d win=%0d",
                   $time, playerXPosition, playerYPosition, bulletXPosition, bulletYPosition, win,
                   m_x, m_bx, m_by, m_win);
        end
      end
    end
  end

  function automatic row_t mk(input logic st, l, r, sp, sh, lo,
                              input int ex, ey, t, x, bx, by, w);
    row_t v;
    v.st = st; v.l = l; v.r = r; v.sp = sp; v.sh = sh; v.lo = lo;
    v.ex = ex; v.ey = ey; v.ticks = t; v.x = x; v.bx = bx; v.by = by; v.w = w;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input int x, bx, by, w);
    n_vec++;
    if (playerXPosition !== 10'(x) || playerYPosition !== 9'd440 ||
        bulletXPosition !== 10'(bx) || bulletYPosition !== 9'(by) || win !== 1'(w)) begin
      n_err++;
      $display("FAIL %s[%0d] got x=%0d y=%0d bx=%0d by=%0d win=%0d want x=%0d y=440 bx=%0d by=%0d win=%0d",
               name, idx, playerXPosition, playerYPosition, bulletXPosition, bulletYPosition, win,
               x, bx, by, w);
    end
  endtask

  initial begin
    //          st l r sp sh lo  ex   ey  ticks  x   bx  by  w
    tbl.push_back(mk(0,0,0,0,0,0, 900,100,   2, 315,  0,  0, 0));
    tbl.push_back(mk(1,0,0,0,0,0, 900,100,  20, 315,  0,  0, 0));
    tbl.push_back(mk(0,1,0,0,0,0, 900,100,   1, 313,  0,  0, 0));
    tbl.push_back(mk(0,1,0,0,0,0, 900,100, 144,  25,  0,  0, 0));
    tbl.push_back(mk(0,1,0,0,0,0, 900,100,   1,  23,  0,  0, 0));
    tbl.push_back(mk(0,1,0,0,0,0, 900,100,   1,  21,  0,  0, 0));
    tbl.push_back(mk(0,1,0,0,0,0, 900,100,   2,  21,  0,  0, 0));
    tbl.push_back(mk(0,1,0,1,0,0, 900,100,   3,  21,  0,  0, 0));
    tbl.push_back(mk(0,0,1,0,0,0, 900,100,   1,  23,  0,  0, 0));
    tbl.push_back(mk(0,0,1,0,0,0, 900,100, 146, 315,  0,  0, 0));
    tbl.push_back(mk(0,0,0,1,0,0, 900,100,   1, 315,  0,  0, 0));
    tbl.push_back(mk(0,0,0,0,1,0, 900,100,   1, 315,315,420, 0));
    tbl.push_back(mk(0,0,0,0,0,0, 900,100,   1, 315,315,416, 0));
    tbl.push_back(mk(0,0,0,0,1,0, 900,100,   1, 315,315,412, 0));
    tbl.push_back(mk(0,0,0,0,0,0, 900,100,   1, 315,315,408, 0));
    tbl.push_back(mk(0,0,0,0,0,0, 900,100,  99, 315,315, 12, 0));
    tbl.push_back(mk(0,0,0,0,0,0, 900,100,   1, 315,  0,  0, 0));
    tbl.push_back(mk(0,0,0,0,0,0, 315,200,  16, 315,  0,  0, 0));
    tbl.push_back(mk(0,0,0,0,1,0, 315,200,   1, 315,315,420, 0));
    tbl.push_back(mk(0,0,0,0,0,0, 315,200,  50, 315,315,220, 0));
    tbl.push_back(mk(0,0,0,0,0,0, 315,200,   1, 315,315,216, 0));
    tbl.push_back(mk(0,0,0,0,0,0, 315,200,   1, 315,  0,  0, 1));
    tbl.push_back(mk(0,1,0,0,0,0, 315,200,   3, 315,  0,  0, 1));
    tbl.push_back(mk(1,0,0,1,0,0, 900,100,   1, 315,  0,  0, 0));
    tbl.push_back(mk(0,0,0,0,1,0, 900,100,   1, 315,315,420, 0));
    tbl.push_back(mk(0,0,0,0,0,0, 900,100,   2, 315,315,412, 0));
    tbl.push_back(mk(0,0,1,0,0,1, 900,100,   5, 315,315,412, 0));
    tbl.push_back(mk(0,0,1,0,0,0, 900,100,   1, 317,315,408, 0));
    tbl.push_back(mk(0,0,0,1,0,0, 900,100,   1, 317,315,404, 0));
    tbl.push_back(mk(0,0,0,0,0,0, 900,100, 101, 317,  0,  0, 0));
`ifdef SHOT_COOLDOWN_EN
    tbl.push_back(mk(0,0,0,0,0,0, 900,100,   2, 317,  0,  0, 0));
    tbl.push_back(mk(0,0,0,0,1,0, 900,100,   1, 317,  0,  0, 0));
    tbl.push_back(mk(0,0,0,0,0,0, 900,100,  12, 317,  0,  0, 0));
    tbl.push_back(mk(0,0,0,0,1,0, 900,100,   1, 317,317,420, 0));
`else
    tbl.push_back(mk(0,0,0,0,1,0, 900,100,   1, 317,317,420, 0));
`endif

    #1 resetn = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge master_clk);
    chk("reset", 0, 315, 0, 0, 0);
    resetn = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      start = tbl[i].st; left = tbl[i].l; right = tbl[i].r; stop = tbl[i].sp;
      shoot = tbl[i].sh; lose = tbl[i].lo;
      enemyXPosition = 10'(tbl[i].ex);
      enemyYPosition = 9'(tbl[i].ey);
      repeat (TD * tbl[i].ticks) @(negedge master_clk);
      chk("row", i, tbl[i].x, tbl[i].bx, tbl[i].by, tbl[i].w);
    end

    // Relaunch, leave a shot pending, then reset asynchronously between edges
    start = 1'b0; left = 1'b0; right = 1'b0; stop = 1'b0; lose = 1'b0;
    shoot = 1'b0;
    repeat (TD * 30) @(negedge master_clk);
    shoot = 1'b1;
    @(negedge master_clk);
    shoot = 1'b0;
    @(negedge master_clk);
    #2 resetn = 1'b0;
    #1 chk("async_reset", 0, 315, 0, 0, 0);
    repeat (2) @(negedge master_clk);
    resetn = 1'b1;
    repeat (TD * 3) @(negedge master_clk);
    chk("post_reset_idle", 0, 315, 0, 0, 0);
    start = 1'b1;
    repeat (TD * 2) @(negedge master_clk);
    chk("post_reset_play", 0, 315, 0, 0, 0);

    // Random keypad activity checked every cycle against the model
    for (int k = 0; k < 1500; k++) begin
      start = ($urandom_range(0, 99) < 2);
      stop  = ($urandom_range(0, 9) == 0);
      left  = ($urandom_range(0, 5) == 0);
      right = ($urandom_range(0, 5) == 0);
      shoot = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 29) == 0) lose = ~lose;
      if ($urandom_range(0, 49) == 0) begin
        enemyXPosition = 10'($urandom_range(250, 380));
        enemyYPosition = 9'($urandom_range(100, 420));
      end
      repeat ($urandom_range(1, 6)) @(negedge master_clk);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
